// File: rtl/exec_cc_stage.sv
// rtl/exec_cc_stage.sv - Y86-64 registered execute stage with ALU, condition codes and branch condition
module exec_cc_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             bubble,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] aluA,
    input  logic [WIDTH-1:0] aluB,
    input  logic             set_cc,
    input  logic [3:0]       cond_fn,
    output logic             out_valid,
    output logic [WIDTH-1:0] valE,
    output logic             cnd,
    output logic             out_err,
    output logic [2:0]       cc
);

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_XOR = 4'd3;

    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;

    localparam logic [2:0] CC_RESET = 3'b100;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] val_e_q, val_e_d;
    logic             cnd_q, cnd_d;
    logic             err_q, err_d;
    logic [2:0]       cc_q, cc_d;

    logic [WIDTH-1:0] result;
    logic             fn_legal, cond_legal, cond_val;
    logic             zf_new, sf_new, of_new;
    logic             zf, sf, of;

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    always_comb begin
        result   = '0;
        of_new   = 1'b0;
        fn_legal = 1'b1;
        case (ifun)
            FN_ADD: begin
                result = aluB + aluA;
                of_new = (aluA[WIDTH-1] == aluB[WIDTH-1]) && (result[WIDTH-1] != aluA[WIDTH-1]);
            end
            FN_SUB: begin
                result = aluB - aluA;
                of_new = (aluA[WIDTH-1] != aluB[WIDTH-1]) && (result[WIDTH-1] != aluB[WIDTH-1]);
            end
            FN_AND:  result = aluA & aluB;
            FN_XOR:  result = aluA ^ aluB;
            default: fn_legal = 1'b0;
        endcase
        zf_new = (result == '0);
        sf_new = result[WIDTH-1];
    end

    // Condition looks at the flags held before this instruction, so a cmov right
    // after an OPq sees that OPq's flags with no extra bubble.
    always_comb begin
        cond_val   = 1'b0;
        cond_legal = 1'b1;
        case (cond_fn)
            C_ALWAYS: cond_val = 1'b1;
            C_LE:     cond_val = (sf ^ of) | zf;
            C_L:      cond_val = sf ^ of;
            C_E:      cond_val = zf;
            C_NE:     cond_val = ~zf;
            C_GE:     cond_val = ~(sf ^ of);
            C_G:      cond_val = ~(sf ^ of) & ~zf;
            default:  cond_legal = 1'b0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        val_e_d     = val_e_q;
        cnd_d       = cnd_q;
        err_d       = err_q;
        cc_d        = cc_q;
        if (bubble) begin
            out_valid_d = 1'b0;
            val_e_d     = '0;
            cnd_d       = 1'b0;
            err_d       = 1'b0;
        end else if (!stall) begin
            out_valid_d = in_valid;
            if (in_valid) begin
                val_e_d = result;
                cnd_d   = cond_val;
                err_d   = ~fn_legal | ~cond_legal;
                if (set_cc && fn_legal) begin
                    cc_d = {zf_new, sf_new, of_new};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            val_e_q     <= '0;
            cnd_q       <= 1'b0;
            err_q       <= 1'b0;
            cc_q        <= CC_RESET;
        end else begin
            out_valid_q <= out_valid_d;
            val_e_q     <= val_e_d;
            cnd_q       <= cnd_d;
            err_q       <= err_d;
            cc_q        <= cc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign valE      = val_e_q;
    assign cnd       = cnd_q;
    assign out_err   = err_q;
    assign cc        = cc_q;

endmodule
